// File: rtl/mem2_load_stage_pkg.sv
// CPU_Defines: load-op and MEM2 FSM encodings shared by the MEM2 load stage and its aligner.
package CPU_Defines;

   typedef enum logic [2:0] {
      LD_LB  = 3'd0,
      LD_LBU = 3'd1,
      LD_LH  = 3'd2,
      LD_LHU = 3'd3,
      LD_LW  = 3'd4,
      LD_LWL = 3'd5,
      LD_LWR = 3'd6
   } ld_op_t;

   typedef enum logic [1:0] {
      MEM2_IDLE  = 2'd0,
      MEM2_WAIT  = 2'd1,
      MEM2_DONE  = 2'd2,
      MEM2_DRAIN = 2'd3
   } mem2_state_t;

   function automatic logic [31:0] sext8(input logic [7:0] b);
      return {{24{b[7]}}, b};
   endfunction

   function automatic logic [31:0] sext16(input logic [15:0] h);
      return {{16{h[15]}}, h};
   endfunction

endpackage

// File: rtl/mem2_load_align.sv
// Combinational load aligner: selects and extends the addressed byte/half of a little-endian word.
// LWL/LWR merging is built only when MEM2_UNALIGNED_LOAD_EN is defined; otherwise they act as LW.
module mem2_load_align
   import CPU_Defines::*;
(
   input  ld_op_t      ld_op,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rdata,
   input  logic [31:0] old_rt,
   output logic [31:0] wdata
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

`ifndef MEM2_UNALIGNED_LOAD_EN
   logic unused_old_rt;
   assign unused_old_rt = ^old_rt;
`endif

   always_comb begin
      case (addr_lo)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      wdata    = rdata;
      case (ld_op)
         LD_LB:  wdata = sext8(byte_sel);
         LD_LBU: wdata = {24'd0, byte_sel};
         LD_LH:  wdata = sext16(half_sel);
         LD_LHU: wdata = {16'd0, half_sel};
`ifdef MEM2_UNALIGNED_LOAD_EN
         // LWL fills the upper bytes from memory, LWR the lower bytes; the rest keeps old rt.
         LD_LWL: begin
            case (addr_lo)
               2'd0:    wdata = {rdata[7:0],  old_rt[23:0]};
               2'd1:    wdata = {rdata[15:0], old_rt[15:0]};
               2'd2:    wdata = {rdata[23:0], old_rt[7:0]};
               default: wdata = rdata;
            endcase
         end
         LD_LWR: begin
            case (addr_lo)
               2'd0:    wdata = rdata;
               2'd1:    wdata = {old_rt[31:24], rdata[31:8]};
               2'd2:    wdata = {old_rt[31:16], rdata[31:16]};
               default: wdata = {old_rt[31:8],  rdata[31:24]};
            endcase
         end
`endif
         default: wdata = rdata;
      endcase
   end

endmodule

// File: rtl/mem2_load_stage.sv
// MEM2 stage: holds the MEM instruction, waits for the DCache load response and produces final writeback data.
// Define MEM2_UNALIGNED_LOAD_EN to enable LWL/LWR merging in the aligner.
module mem2_load_stage
   import CPU_Defines::*;
#(
   parameter int DATA_W = 32,
   parameter int PC_W   = 32
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              mem2_flush,
   input  logic              mem2_wr,
   input  logic              mem_valid,
   input  logic              mem_except,
   input  logic [PC_W-1:0]   mem_pc,
   input  logic [31:0]       mem_addr,
   input  logic              mem_ld_en,
   input  logic [2:0]        mem_ld_op,
   input  logic [DATA_W-1:0] mem_result,
   input  logic [4:0]        mem_dst,
   input  logic              mem_rf_we,
   input  logic              dcache_rvalid,
   input  logic [DATA_W-1:0] dcache_rdata,
   output logic              mem2_stall_req,
   output logic              mem2_valid,
   output logic [PC_W-1:0]   mem2_pc,
   output logic [4:0]        mem2_dst,
   output logic              mem2_rf_we,
   output logic [DATA_W-1:0] mem2_wdata,
   output logic              mem2_fwd_ok
);

   mem2_state_t       state_q, state_d;
   logic [1:0]        drop_q, drop_d;
   logic              valid_q, valid_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [4:0]        dst_q, dst_d;
   logic              rf_we_q, rf_we_d;
   ld_op_t            op_q, op_d;
   logic [1:0]        addr_lo_q, addr_lo_d;
   logic [DATA_W-1:0] data_q, data_d;

   logic              resp_use, hold_wait, capture, live;
   logic [DATA_W-1:0] align_wdata;
   logic              unused_addr_hi;

   assign unused_addr_hi = ^mem_addr[31:2];

   mem2_load_align u_align (
      .ld_op   (op_q),
      .addr_lo (addr_lo_q),
      .rdata   (dcache_rdata),
      .old_rt  (data_q),
      .wdata   (align_wdata)
   );

   // drop_q counts responses still owed to flushed loads; they are consumed before any live one.
   always_comb begin
      resp_use  = dcache_rvalid && (drop_q == 2'd0) && (state_q == MEM2_WAIT);
      hold_wait = (state_q == MEM2_WAIT) && !resp_use;
      capture   = mem2_wr && !mem2_flush && !hold_wait;
      live      = mem_valid && !mem_except;

      state_d   = state_q;
      drop_d    = drop_q;
      valid_d   = valid_q;
      pc_d      = pc_q;
      dst_d     = dst_q;
      rf_we_d   = rf_we_q;
      op_d      = op_q;
      addr_lo_d = addr_lo_q;
      data_d    = data_q;

      if (dcache_rvalid && (drop_q != 2'd0))
         drop_d = drop_q - 2'd1;
      if (resp_use)
         data_d = align_wdata;

      if (mem2_flush) begin
         valid_d = 1'b0;
         rf_we_d = 1'b0;
         pc_d    = '0;
         dst_d   = '0;
         data_d  = '0;
         if (hold_wait && (drop_d != 2'd3))
            drop_d = drop_d + 2'd1;
         state_d = (drop_d != 2'd0) ? MEM2_DRAIN : MEM2_IDLE;
      end else if (capture) begin
         valid_d   = live;
         pc_d      = mem_pc;
         dst_d     = mem_dst;
         rf_we_d   = live && mem_rf_we;
         op_d      = ld_op_t'(mem_ld_op);
         addr_lo_d = mem_addr[1:0];
         data_d    = mem_result;
         if (live && mem_ld_en)
            state_d = MEM2_WAIT;
         else
            state_d = (drop_d != 2'd0) ? MEM2_DRAIN : MEM2_IDLE;
      end else if (resp_use) begin
         state_d = MEM2_DONE;
      end else if ((state_q == MEM2_DRAIN) && (drop_d == 2'd0)) begin
         state_d = MEM2_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= MEM2_IDLE;
         drop_q    <= 2'd0;
         valid_q   <= 1'b0;
         pc_q      <= '0;
         dst_q     <= '0;
         rf_we_q   <= 1'b0;
         op_q      <= LD_LW;
         addr_lo_q <= 2'd0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         drop_q    <= drop_d;
         valid_q   <= valid_d;
         pc_q      <= pc_d;
         dst_q     <= dst_d;
         rf_we_q   <= rf_we_d;
         op_q      <= op_d;
         addr_lo_q <= addr_lo_d;
         data_q    <= data_d;
      end
   end

   // The response is passed straight through in its arrival cycle so the stall can drop immediately.
   always_comb begin
      mem2_stall_req = hold_wait;
      mem2_valid     = valid_q;
      mem2_pc        = pc_q;
      mem2_dst       = dst_q;
      mem2_rf_we     = rf_we_q;
      mem2_fwd_ok    = valid_q && (state_q != MEM2_WAIT);
      mem2_wdata     = (state_q == MEM2_WAIT) ? align_wdata : data_q;
   end

endmodule
